// File: rtl/dithering_rgb.sv
// Per-channel colour depth reducer: truncation, error diffusion or
// 2x2 ordered dithering, one registered stage.
module dithering_rgb #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 4,
  parameter int CHANNELS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*IN_BITS-1:0]  pixel_in,
  input  logic                         visible,
  input  logic                         frame_start,
  input  logic [1:0]                   mode,
  output logic [CHANNELS*OUT_BITS-1:0] pixel_out,
  output logic                         visible_out
);

  localparam int D = IN_BITS - OUT_BITS;

  generate
    if (D < 2) begin : g_bad_width
      $error("dithering_rgb: IN_BITS-OUT_BITS must be >= 2");
    end
  endgenerate

  logic         x_q, x_d;
  logic         y_q, y_d;
  logic         vis_q;
  logic         mode_err;
  logic         mode_ord;
  logic [1:0]   bayer;
  logic [D-1:0] thr;

  // Decode the mode; 11 falls back to plain truncation.
  always_comb begin
    mode_err = 1'b0;
    mode_ord = 1'b0;
    unique case (1'b1)
      (mode == 2'b01): mode_err = 1'b1;
      (mode == 2'b10): mode_ord = 1'b1;
      default: ;
    endcase
  end

  // Screen position: x alternates along a line, y per line.
  always_comb begin
    x_d = visible ? ~x_q : 1'b0;
    y_d = y_q;
    if (vis_q && !visible) begin
      y_d = ~y_q;
    end
    if (frame_start) begin
      y_d = 1'b0;
    end
  end

  // Position and visibility pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= 1'b0;
      y_q   <= 1'b0;
      vis_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      vis_q <= visible;
    end
  end

  assign visible_out = vis_q;

  // 2x2 Bayer matrix {0,2,3,1} indexed by y*2+x, scaled to D bits.
  always_comb begin
    bayer = 2'd0;
    unique case ({y_q, x_q})
      2'b00:   bayer = 2'd0;
      2'b01:   bayer = 2'd2;
      2'b10:   bayer = 2'd3;
      default: bayer = 2'd1;
    endcase
    thr = D'(bayer) << (D - 2);
  end

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic [IN_BITS-1:0]  ch;
      logic [IN_BITS:0]    sum;
      logic [OUT_BITS-1:0] q_ch;
      logic [D-1:0]        r_ch;
      logic [OUT_BITS-1:0] q_sum;
      logic [D-1:0]        r_sum;
      logic [D-1:0]        err_q, err_d;
      logic [OUT_BITS-1:0] pix_q, pix_d;

      assign ch    = pixel_in[c*IN_BITS +: IN_BITS];
      assign sum   = {1'b0, ch} + {{(OUT_BITS+1){1'b0}}, err_q};
      assign q_ch  = ch[IN_BITS-1 -: OUT_BITS];
      assign r_ch  = ch[D-1:0];
      assign q_sum = sum[IN_BITS-1 -: OUT_BITS];
      assign r_sum = sum[D-1:0];

      // Quantise one channel; error only carries within a visible mode-01 run.
      always_comb begin
        pix_d = '0;
        err_d = '0;
        if (visible) begin
          unique case (1'b1)
            mode_err: begin
              if (sum[IN_BITS]) begin
                pix_d = '1;
              end else begin
                pix_d = q_sum;
                if (!frame_start) begin
                  err_d = r_sum;
                end
              end
            end
            mode_ord: begin
              if ((r_ch > thr) && (q_ch != '1)) begin
                pix_d = q_ch + OUT_BITS'(1);
              end else begin
                pix_d = q_ch;
              end
            end
            default: pix_d = q_ch;
          endcase
        end
      end

      // Channel output and carried error.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pix_q <= '0;
          err_q <= '0;
        end else begin
          pix_q <= pix_d;
          err_q <= err_d;
        end
      end

      assign pixel_out[c*OUT_BITS +: OUT_BITS] = pix_q;
    end
  endgenerate

endmodule
